// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - 4-thread round-robin fetch scheduler with stall parking and branch redirect
// Optional THREAD_SCHEDULER_PERF_EN adds a saturating idle-cycle counter output idle_cnt_o.
module thread_scheduler #(
    parameter int PC_WIDTH     = 9,
    parameter int STALL_CYCLES = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [3:0]          thread_en_i,
    input  logic                stall_req_i,
    input  logic [1:0]          stall_tid_i,
    input  logic                branch_taken_i,
    input  logic [1:0]          branch_tid_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic                issue_valid_o,
    output logic [1:0]          issue_tid_o,
    output logic [PC_WIDTH-1:0] issue_pc_o,
    output logic                idle_o
`ifdef THREAD_SCHEDULER_PERF_EN
    ,
    output logic [31:0]         idle_cnt_o
`endif
);

    logic [PC_WIDTH-1:0] pc [4];
    logic [3:0]          stall_cnt [4];
    logic [1:0]          last;
    logic [3:0]          eligible;
    logic [1:0]          winner;
    logic [1:0]          cand;
    logic                any_eligible;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            eligible[n] = thread_en_i[n] && (stall_cnt[n] == 4'd0);
        end
    end

    // Search last+1 .. last+4; the 2-bit sum wraps modulo 4 naturally.
    always_comb begin
        winner       = last;
        any_eligible = 1'b0;
        cand         = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!any_eligible && eligible[cand]) begin
                winner       = cand;
                any_eligible = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < 4; n++) begin
                pc[n]        <= '0;
                stall_cnt[n] <= '0;
            end
            last          <= 2'd3;
            issue_valid_o <= 1'b0;
            issue_tid_o   <= 2'd0;
            issue_pc_o    <= '0;
            idle_o        <= 1'b0;
        end else begin
            issue_valid_o <= any_eligible;
            if (any_eligible) begin
                issue_tid_o <= winner;
                issue_pc_o  <= pc[winner];
                last        <= winner;
                idle_o      <= 1'b0;
            end else begin
                idle_o      <= 1'b1;
            end

            for (int n = 0; n < 4; n++) begin
                if (stall_req_i && (stall_tid_i == 2'(n))) begin
                    stall_cnt[n] <= 4'(STALL_CYCLES);
                end else if (stall_cnt[n] != 4'd0) begin
                    stall_cnt[n] <= stall_cnt[n] - 4'd1;
                end

                // A redirect wins over the post-issue increment of the same thread.
                if (branch_taken_i && (branch_tid_i == 2'(n))) begin
                    pc[n] <= branch_target_i;
                end else if (any_eligible && (winner == 2'(n))) begin
                    pc[n] <= pc[n] + PC_WIDTH'(1);
                end
            end
        end
    end

`ifdef THREAD_SCHEDULER_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_o <= '0;
        end else if (!any_eligible && (idle_cnt_o != 32'hFFFF_FFFF)) begin
            idle_cnt_o <= idle_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - self-checking bench for thread_scheduler against a behavioural model
module tb_thread_scheduler;

    localparam int PCW   = 9;
    localparam int STALL = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     thread_en;
    logic           stall_req;
    logic [1:0]     stall_tid;
    logic           branch_taken;
    logic [1:0]     branch_tid;
    logic [PCW-1:0] branch_target;
    logic           issue_valid;
    logic [1:0]     issue_tid;
    logic [PCW-1:0] issue_pc;
    logic           idle;
`ifdef THREAD_SCHEDULER_PERF_EN
    logic [31:0]    idle_cnt;
`endif

    thread_scheduler #(.PC_WIDTH(PCW), .STALL_CYCLES(STALL)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .thread_en_i    (thread_en),
        .stall_req_i    (stall_req),
        .stall_tid_i    (stall_tid),
        .branch_taken_i (branch_taken),
        .branch_tid_i   (branch_tid),
        .branch_target_i(branch_target),
        .issue_valid_o  (issue_valid),
        .issue_tid_o    (issue_tid),
        .issue_pc_o     (issue_pc),
        .idle_o         (idle)
`ifdef THREAD_SCHEDULER_PERF_EN
        ,
        .idle_cnt_o     (idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, one entry per thread.
    int m_pc [4];
    int m_cnt [4];
    int m_last, m_valid, m_tid, m_opc, m_idle;
    int m_idle_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_pc[n]  = 0;
            m_cnt[n] = 0;
        end
        m_last = 3; m_valid = 0; m_tid = 0; m_opc = 0; m_idle = 0; m_idle_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 32'(issue_valid), m_valid);
        check({tag, "_tid"},   32'(issue_tid),   m_tid);
        check({tag, "_pc"},    32'(issue_pc),    m_opc);
        check({tag, "_idle"},  32'(idle),        m_idle);
`ifdef THREAD_SCHEDULER_PERF_EN
        check({tag, "_idlecnt"}, idle_cnt, m_idle_cnt);
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input logic [3:0] en, input logic sreq, input logic [1:0] stid,
                         input logic breq, input logic [1:0] btid, input logic [PCW-1:0] btgt);
        int w;
        thread_en = en; stall_req = sreq; stall_tid = stid;
        branch_taken = breq; branch_tid = btid; branch_target = btgt;
        @(posedge clk);
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            int t;
            t = (m_last + k) % 4;
            if (w < 0 && en[t] && m_cnt[t] == 0) w = t;
        end
        for (int n = 0; n < 4; n++) begin
            if (sreq && int'(stid) == n) m_cnt[n] = STALL;
            else if (m_cnt[n] > 0)      m_cnt[n] = m_cnt[n] - 1;
        end
        if (w >= 0) begin
            m_valid = 1; m_tid = w; m_opc = m_pc[w]; m_idle = 0; m_last = w;
            m_pc[w] = (m_pc[w] + 1) % (1 << PCW);
        end else begin
            m_valid = 0; m_idle = 1;
            if (m_idle_cnt != 32'hFFFF_FFFF) m_idle_cnt++;
        end
        if (breq) m_pc[btid] = int'(btgt);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle_cycle(input string tag, input logic [3:0] en);
        cycle(tag, en, 1'b0, 2'd0, 1'b0, 2'd0, '0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_valid", 32'(issue_valid), 32'd0);
        check("rst_async_tid",   32'(issue_tid),   32'd0);
        check("rst_async_pc",    32'(issue_pc),    32'd0);
        check("rst_async_idle",  32'(idle),        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; thread_en = 4'h0; stall_req = 1'b0; stall_tid = 2'd0;
        branch_taken = 1'b0; branch_tid = 2'd0; branch_target = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // All enabled: 0,1,2,3,0,... with per-thread pc 0,0,0,0,1,...
        for (int i = 0; i < 8; i++) begin
            idle_cycle("rr_all", 4'hF);
            check("rr_all_tid_seq", 32'(issue_tid), 32'(i % 4));
            check("rr_all_pc_seq",  32'(issue_pc),  32'(i / 4));
        end

        // Stall thread 1 on the edge it issues; it is skipped for 3 selections.
        idle_cycle("st_pre", 4'hF);
        cycle("st_hit", 4'hF, 1'b1, 2'd1, 1'b0, 2'd0, '0);
        check("st_hit_tid", 32'(issue_tid), 32'd1);
        for (int i = 0; i < 6; i++) idle_cycle("st_after", 4'hF);

        // Redirect thread 2 in the cycle it issues.
        while (!(m_last == 1 && m_cnt[2] == 0)) idle_cycle("br_align", 4'hF);
        cycle("br_hit", 4'hF, 1'b0, 2'd0, 1'b1, 2'd2, 9'h1F0);
        check("br_hit_tid", 32'(issue_tid), 32'd2);
        for (int i = 0; i < 8; i++) idle_cycle("br_after", 4'hF);

        // Simultaneous stall and branch, same thread and different threads.
        cycle("sb_same", 4'hF, 1'b1, 2'd3, 1'b1, 2'd3, 9'h055);
        cycle("sb_diff", 4'hF, 1'b1, 2'd0, 1'b1, 2'd1, 9'h0AA);
        for (int i = 0; i < 6; i++) idle_cycle("sb_after", 4'hF);

        // Nothing enabled for 5 cycles, then thread 3 alone resumes with its held pc.
        pulse_reset();
`ifdef THREAD_SCHEDULER_PERF_EN
        check("perf_reset", idle_cnt, 32'd0);
`endif
        for (int i = 0; i < 5; i++) idle_cycle("idle", 4'h0);
        check("idle_flag", 32'(idle), 32'd1);
`ifdef THREAD_SCHEDULER_PERF_EN
        check("idle_cnt5", idle_cnt, 32'd5);
`endif
        idle_cycle("resume3", 4'h8);
        check("resume3_tid", 32'(issue_tid), 32'd3);

        // Only threads 0 and 2 enabled after reset: 0,2,0,2,...
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            idle_cycle("en0101", 4'b0101);
            check("en0101_tid", 32'(issue_tid), (i % 2 == 0) ? 32'd0 : 32'd2);
        end

        // PC wrap: park thread 0 at 0x1FF and watch it roll over to 0.
        cycle("wrap_set", 4'h1, 1'b0, 2'd0, 1'b1, 2'd0, 9'h1FF);
        idle_cycle("wrap_top", 4'h1);
        check("wrap_top_pc", 32'(issue_pc), 32'h1FF);
        idle_cycle("wrap_zero", 4'h1);
        check("wrap_zero_pc", 32'(issue_pc), 32'h000);

        // Pending stall and redirect are discarded by reset.
        cycle("pend", 4'hF, 1'b1, 2'd0, 1'b1, 2'd1, 9'h123);
        pulse_reset();
        idle_cycle("post_rst", 4'hF);
        check("post_rst_tid", 32'(issue_tid), 32'd0);
        check("post_rst_pc",  32'(issue_pc),  32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            cycle("rand", en, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 6) == 0), 2'($urandom_range(0, 3)), PCW'($urandom_range(0, 511)));
            if (i == 200) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 9, giving the per-thread program counter width.
REQ-002 The block SHALL have parameter STALL_CYCLES, default 3, giving the park duration in cycles after a stall request (range 1..15).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port thread_en_i, input, 4 bits: per-thread enable; bit n enables thread n.
REQ-006 The block SHALL have port stall_req_i, input, 1 bit: park the thread named by stall_tid_i.
REQ-007 The block SHALL have port stall_tid_i, input, 2 bits: thread to park.
REQ-008 The block SHALL have port branch_taken_i, input, 1 bit: redirect the PC of thread branch_tid_i.
REQ-009 The block SHALL have port branch_tid_i, input, 2 bits: thread to redirect.
REQ-010 The block SHALL have port branch_target_i, input, PC_WIDTH bits: new PC for the redirect.
REQ-011 The block SHALL have port issue_valid_o, output, 1 bit: an instruction fetch is issued this cycle.
REQ-012 The block SHALL have port issue_tid_o, output, 2 bits: thread id of the issued fetch, carried down the pipeline registers.
REQ-013 The block SHALL have port issue_pc_o, output, PC_WIDTH bits: PC of the issued fetch.
REQ-014 The block SHALL have port idle_o, output, 1 bit: high when no thread was eligible last cycle.

Function
REQ-015 The block SHALL hold, per thread: a PC register (PC_WIDTH bits), a 4-bit stall counter, and a 2-bit last-issued pointer shared by all threads.
REQ-016 Thread n SHALL be eligible iff thread_en_i[n]=1 and its registered stall counter = 0.
REQ-017 Selection SHALL be round-robin, searching from last+1 through last+4, modulo 4; the first eligible thread wins.
REQ-018 On each edge with at least one eligible thread:
- issue_valid_o <= 1, issue_tid_o <= winner, issue_pc_o <= PC[winner];
- PC[winner] <= PC[winner]+1, wrapping modulo 2^PC_WIDTH;
- last <= winner.
REQ-019 With no eligible thread:
- issue_valid_o <= 0 and idle_o <= 1;
- issue_tid_o, issue_pc_o, last and all PCs hold.
REQ-020 idle_o <= 0 on any edge where a thread issues.
REQ-021 Latency: outputs SHALL be registered; inputs sampled at edge k affect outputs after edge k only.
REQ-022 stall_req_i SHALL load counter[stall_tid_i] with STALL_CYCLES; eligibility uses the pre-edge counter, so a thread selected in the same cycle still issues.
REQ-023 Each nonzero counter not being loaded SHALL decrement by 1 per cycle and saturate at 0.
REQ-024 branch_taken_i SHALL load PC[branch_tid_i] <= branch_target_i.
REQ-025 If the branch targets the thread issuing that cycle, the branch load SHALL override the increment; the issue still uses the old PC.
REQ-026 Simultaneous stall and branch, to the same or different threads, SHALL both take effect.
REQ-027 Deasserting thread_en_i[n] SHALL only block selection; PC[n] and counter[n] continue their normal updates.

Reset
REQ-028 While rst_ni=0, all state SHALL be forced immediately, independent of clk_i:
- every PC = 0 and every stall counter = 0;
- last = 3, so thread 0 is first after reset;
- issue_valid_o = 0, issue_tid_o = 0, issue_pc_o = 0, idle_o = 0.
REQ-029 Reset asserted mid-operation SHALL discard all pending stalls and redirects.
REQ-030 The first selection SHALL occur on the first rising edge after rst_ni is released.

Configuration
REQ-031 Macro THREAD_SCHEDULER_PERF_EN SHALL add output idle_cnt_o, 32 bits:
- counts edges with no eligible thread;
- saturates at 0xFFFFFFFF;
- resets to 0.
REQ-032 Without THREAD_SCHEDULER_PERF_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Scenario: reset release, thread_en_i=4'b1111, no stalls -> issue_tid_o sequence 0,1,2,3,0,…; pc 0,0,0,0,1,… per thread; issue_valid_o constantly 1.
REQ-034 Scenario: thread_en_i=4'b0101 -> tids alternate 2,0,2,0 after the first issue of 0.
REQ-035 Scenario: stall_req_i with tid 1 at the edge that issues thread 1, STALL_CYCLES=3, all enabled -> thread 1 issues, then is skipped for 3 cycles, then is eligible again.
REQ-036 Scenario: branch_taken_i tid 2, target 9'h1F0, in the cycle thread 2 issues at pc 5 -> that issue shows pc 5; the next thread-2 issue shows 0x1F0, then 0x1F1.
REQ-037 Scenario: thread_en_i=0 for 5 cycles -> issue_valid_o=0 and idle_o=1; with the macro, idle_cnt_o=5; re-enabling thread 3 -> thread 3 issues with its held PC.
REQ-038 Scenario: PC at 9'h1FF issues -> the next issue of that thread shows pc 0; rst_ni pulsed low mid-stream -> outputs zero immediately and the sequence restarts at tid 0, pc 0.
